// File: rtl/axis2difftest.sv
// Reassembles AXI-Stream beats into one DATA_WIDTH-bit difftest batch word,
// dropping malformed packets with one-cycle error pulses.
`ifndef CONFIG_DIFFTEST_BATCH_IO_WITDH
`define CONFIG_DIFFTEST_BATCH_IO_WITDH 1200
`endif

module axis2difftest #(
    parameter int DATA_WIDTH      = `CONFIG_DIFFTEST_BATCH_IO_WITDH,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [AXIS_DATA_WIDTH-1:0]   axi_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] axi_tkeep,
    input  logic                         axi_tlast,
    input  logic                         axi_tvalid,
    output logic                         axi_tready,
    output logic [DATA_WIDTH-1:0]        difftest_data,
    output logic                         difftest_valid,
    input  logic                         difftest_ready,
    output logic                         err_short,
    output logic                         err_long,
    output logic                         err_keep,
    output logic [31:0]                  pkt_count
);
    localparam int KEEP_W     = AXIS_DATA_WIDTH / 8;
    localparam int BEATS      = (DATA_WIDTH + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int LAST_BYTES = (DATA_WIDTH - (BEATS - 1) * AXIS_DATA_WIDTH) / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             bad_reg, bad_next;
    logic [31:0]      pkt_count_reg, pkt_count_next;
    logic             err_short_reg, err_short_next;
    logic             err_long_reg, err_long_next;
    logic             err_keep_reg, err_keep_next;
    logic             wr_en;
    logic             keep_ok;
    logic [KEEP_W-1:0] last_keep;

    genvar gi;

    // Expected tkeep on the final beat: only the bytes that land inside DATA_WIDTH.
    generate
        for (gi = 0; gi < KEEP_W; gi++) begin : g_last_keep
            assign last_keep[gi] = (gi < LAST_BYTES);
        end
    endgenerate

    // One storage slot per beat; the last slot keeps only the bits that survive truncation.
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            localparam int SLOT_W = (gi == BEATS - 1) ? LAST_BYTES * 8 : AXIS_DATA_WIDTH;
            logic [SLOT_W-1:0] slot_reg;

            always_ff @(posedge clock) begin
                if (wr_en && beat_cnt_reg == CNT_W'(gi)) begin
                    slot_reg <= axi_tdata[SLOT_W-1:0];
                end
            end

            assign difftest_data[gi*AXIS_DATA_WIDTH +: SLOT_W] = slot_reg;
        end
    endgenerate

    assign keep_ok = (beat_cnt_reg == LAST_IDX) ? (axi_tkeep == last_keep)
                                                : (axi_tkeep == {KEEP_W{1'b1}});

    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        bad_next       = bad_reg;
        pkt_count_next = pkt_count_reg;
        err_short_next = 1'b0;
        err_long_next  = 1'b0;
        err_keep_next  = 1'b0;
        wr_en          = 1'b0;

        case (state_reg)
            S_COLLECT: begin
                if (axi_tvalid) begin
                    wr_en = 1'b1;
                    if (beat_cnt_reg == LAST_IDX) begin
                        beat_cnt_next = '0;
                        bad_next      = 1'b0;
                        if (!axi_tlast) begin
                            err_long_next = 1'b1;
                            state_next    = S_DISCARD;
                        end else if (bad_reg || !keep_ok) begin
                            err_keep_next = 1'b1;
                        end else begin
                            state_next = S_HOLD;
                        end
                    end else if (axi_tlast) begin
                        err_short_next = 1'b1;
                        beat_cnt_next  = '0;
                        bad_next       = 1'b0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                        bad_next      = bad_reg | ~keep_ok;
                    end
                end
            end
            S_HOLD: begin
                if (difftest_ready) begin
                    pkt_count_next = pkt_count_reg + 32'd1;
                    state_next     = S_COLLECT;
                end
            end
            S_DISCARD: begin
                // Counter and bad flag were already cleared when the overrun was detected.
                if (axi_tvalid && axi_tlast) begin
                    state_next = S_COLLECT;
                end
            end
            default: state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_COLLECT;
            beat_cnt_reg  <= '0;
            bad_reg       <= 1'b0;
            pkt_count_reg <= '0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
            err_keep_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            bad_reg       <= bad_next;
            pkt_count_reg <= pkt_count_next;
            err_short_reg <= err_short_next;
            err_long_reg  <= err_long_next;
            err_keep_reg  <= err_keep_next;
        end
    end

    // Handshake signals decode the state register only, so the consumer's ready
    // never reaches the stream side combinationally.
    assign axi_tready     = (state_reg != S_HOLD);
    assign difftest_valid = (state_reg == S_HOLD);
    assign err_short      = err_short_reg;
    assign err_long       = err_long_reg;
    assign err_keep       = err_keep_reg;
    assign pkt_count      = pkt_count_reg;

endmodule

// File: tb/tb_axis2difftest.sv
// Randomized bench for axis2difftest: packets are described at packet level
// (good/short/long/bad-keep) and the expected outputs follow from those descriptions.
module tb_axis2difftest;
    localparam int DW = 1200;
    localparam int AW = 512;
    localparam logic [63:0] KEEP_LAST = 64'h0000_0000_003F_FFFF;

    logic          clock;
    logic          reset;
    logic [AW-1:0] axi_tdata;
    logic [63:0]   axi_tkeep;
    logic          axi_tlast;
    logic          axi_tvalid;
    logic          axi_tready;
    logic [DW-1:0] difftest_data;
    logic          difftest_valid;
    logic          difftest_ready;
    logic          err_short;
    logic          err_long;
    logic          err_keep;
    logic [31:0]   pkt_count;

    axis2difftest #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .axi_tdata      (axi_tdata),
        .axi_tkeep      (axi_tkeep),
        .axi_tlast      (axi_tlast),
        .axi_tvalid     (axi_tvalid),
        .axi_tready     (axi_tready),
        .difftest_data  (difftest_data),
        .difftest_valid (difftest_valid),
        .difftest_ready (difftest_ready),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_keep       (err_keep),
        .pkt_count      (pkt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ev: what the packet outcome is once this beat is accepted
    // (0 nothing, 1 short, 2 long, 3 keep error, 4 good packet complete).
    typedef struct {
        logic [AW-1:0] d;
        logic [63:0]   k;
        logic          l;
        int            ev;
    } beat_t;

    beat_t         beats_q[$];
    logic [DW-1:0] good_q[$];
    logic          exp_valid;
    logic [31:0]   exp_cnt;
    int            ready_mode;  // 0 always ready, 1 random, 2 never
    bit            gaps;
    int            n_cmp;
    int            n_mis;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_beat();
        logic [AW-1:0] r;
        for (int i = 0; i < AW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // kind: 0 good, 1 short, 2 long, 3 tkeep error
    task automatic add_pkt(input int kind);
        logic [AW-1:0]   d[5];
        logic [63:0]     k[5];
        logic [3*AW-1:0] cat;
        int n;
        int ev;
        int bi;
        case (kind)
            1:       n = 1 + int'($urandom_range(1));
            2:       n = 4 + int'($urandom_range(1));
            default: n = 3;
        endcase
        for (int i = 0; i < n; i++) begin
            d[i] = rand_beat();
            k[i] = (i == 2) ? KEEP_LAST : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        if (kind == 3) begin
            bi = int'($urandom_range(2));
            k[bi] = k[bi] ^ (64'd1 << $urandom_range(63));
        end
        for (int i = 0; i < n; i++) begin
            ev = 0;
            if (kind == 1 && i == n - 1) ev = 1;
            if (kind == 2 && i == 2) ev = 2;
            if (kind == 3 && i == 2) ev = 3;
            if (kind == 0 && i == 2) ev = 4;
            beats_q.push_back('{d: d[i], k: k[i], l: (i == n - 1), ev: ev});
        end
        if (kind == 0) begin
            cat = {d[2], d[1], d[0]};
            good_q.push_back(cat[DW-1:0]);
        end
    endtask

    task automatic step(input logic rst);
        logic hs, ohs, es, el, ek;
        logic [1215:0] o, e;
        beat_t b;
        reset = rst;
        hs  = axi_tvalid && axi_tready && !rst;
        ohs = difftest_valid && difftest_ready && !rst;
        @(posedge clock);
        #1;
        reset = 1'b0;
        es = 1'b0;
        el = 1'b0;
        ek = 1'b0;
        if (rst) begin
            if (exp_valid && good_q.size() > 0) void'(good_q.pop_front());
            exp_valid = 1'b0;
            exp_cnt   = 32'd0;
        end
        if (hs) begin
            b = beats_q.pop_front();
            case (b.ev)
                1: es = 1'b1;
                2: el = 1'b1;
                3: ek = 1'b1;
                4: exp_valid = 1'b1;
                default: ;
            endcase
        end
        if (ohs) begin
            void'(good_q.pop_front());
            exp_valid = 1'b0;
            exp_cnt   = exp_cnt + 32'd1;
        end

        check_eq("err_short", 64'(err_short), 64'(es));
        check_eq("err_long", 64'(err_long), 64'(el));
        check_eq("err_keep", 64'(err_keep), 64'(ek));
        check_eq("difftest_valid", 64'(difftest_valid), 64'(exp_valid));
        check_eq("axi_tready", 64'(axi_tready), 64'(!exp_valid));
        check_eq("pkt_count", 64'(pkt_count), 64'(exp_cnt));
        if (exp_valid && good_q.size() > 0) begin
            o = {16'd0, difftest_data};
            e = {16'd0, good_q[0]};
            for (int i = 0; i < 19; i++) begin
                check_eq($sformatf("data[%0d]", i), o[i*64 +: 64], e[i*64 +: 64]);
            end
        end

        if (!(axi_tvalid && !hs)) begin
            if (beats_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                axi_tvalid = 1'b1;
                axi_tdata  = beats_q[0].d;
                axi_tkeep  = beats_q[0].k;
                axi_tlast  = beats_q[0].l;
            end else begin
                axi_tvalid = 1'b0;
            end
        end
        case (ready_mode)
            0:       difftest_ready = 1'b1;
            1:       difftest_ready = 1'($urandom_range(1));
            default: difftest_ready = 1'b0;
        endcase
    endtask

    task automatic drain(input int max_cycles);
        int cyc;
        cyc = 0;
        while ((beats_q.size() != 0 || axi_tvalid || exp_valid) && cyc < max_cycles) begin
            step(1'b0);
            cyc++;
        end
        check_eq("drain_timeout", 64'(cyc >= max_cycles), 64'd0);
        step(1'b0);
    endtask

    initial begin
        n_cmp          = 0;
        n_mis          = 0;
        exp_valid      = 1'b0;
        exp_cnt        = 32'd0;
        ready_mode     = 0;
        gaps           = 1'b0;
        reset          = 1'b1;
        axi_tvalid     = 1'b0;
        axi_tdata      = '0;
        axi_tkeep      = '0;
        axi_tlast      = 1'b0;
        difftest_ready = 1'b0;

        step(1'b1);
        step(1'b1);
        step(1'b0);

        // Good packet, then short/long/keep-error each followed by a good one.
        add_pkt(0);
        drain(100);
        add_pkt(1); add_pkt(0);
        drain(100);
        add_pkt(2); add_pkt(0);
        drain(100);
        add_pkt(3); add_pkt(0);
        drain(100);

        // Backpressure: consumer stalls while the source keeps offering a second packet.
        ready_mode = 2;
        add_pkt(0); add_pkt(0);
        repeat (16) step(1'b0);
        ready_mode = 0;
        drain(100);

        // Reset after two beats of a packet: the partial packet must be forgotten.
        beats_q.push_back('{d: rand_beat(), k: 64'hFFFF_FFFF_FFFF_FFFF, l: 1'b0, ev: 0});
        beats_q.push_back('{d: rand_beat(), k: 64'hFFFF_FFFF_FFFF_FFFF, l: 1'b0, ev: 0});
        repeat (4) step(1'b0);
        step(1'b1);
        add_pkt(0);
        drain(100);

        // Reset while a packet is held: it must not be delivered or counted.
        ready_mode = 2;
        add_pkt(0);
        repeat (8) step(1'b0);
        step(1'b1);
        ready_mode = 0;
        step(1'b0);
        add_pkt(0);
        drain(100);

        // Counter wrap.
        force dut.pkt_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_reg;
        exp_cnt = 32'hFFFF_FFFF;
        add_pkt(0);
        drain(100);

        // Randomized mix with source gaps and consumer stalls.
        ready_mode = 1;
        gaps       = 1'b1;
        for (int p = 0; p < 150; p++) add_pkt(int'($urandom_range(3)));
        drain(8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
